// File: rtl/lockstep_if.sv
// lockstep_if: golden/DUT bus bundle and checker results for lockstep_compare
interface lockstep_if #(
    parameter int W     = 270,
    parameter int CNT_W = 32
);
    logic             en;
    logic             clr_err;
    logic [W-1:0]     ref_bus;
    logic [W-1:0]     dut_bus;
    logic [W-1:0]     mask;
    logic [W-1:0]     out_bus;
    logic             mismatch;
    logic             err;
    logic             halt;
    logic [W-1:0]     first_diff;
    logic [CNT_W-1:0] first_cycle;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] cycle;
    modport master (
        output en, clr_err, ref_bus, dut_bus, mask,
        input  out_bus, mismatch, err, halt, first_diff, first_cycle, err_count, cycle
    );
    modport slave (
        input  en, clr_err, ref_bus, dut_bus, mask,
        output out_bus, mismatch, err, halt, first_diff, first_cycle, err_count, cycle
    );
endinterface

// File: rtl/lockstep_compare.sv
// lockstep_compare: skew-aligned masked lockstep checker with sticky first-failure capture.
// Optional LOCKSTEP_HALT_EN: registered halt that freezes counters once an error is captured.
module lockstep_compare #(
    parameter int W     = 270,
    parameter int SKEW  = 0,
    parameter int CNT_W = 32
) (
    input logic       clk,
    input logic       rst,
    lockstep_if.slave b
);
    localparam logic [3:0] SK = 4'(SKEW);
    typedef enum logic {WARM, RUN} state_t;
    state_t           st, st_n;
    logic [3:0]       warm;
    logic [W-1:0]     ref_d;
    logic [W-1:0]     diff;
    logic             act;
    logic             hit;
    logic             first;
    logic             halt_q;
    logic             mismatch_q;
    logic             err_q;
    logic [W-1:0]     first_diff_q;
    logic [CNT_W-1:0] first_cycle_q;
    logic [CNT_W-1:0] err_count_q;
    logic [CNT_W-1:0] cycle_q;

    generate
        if (SKEW == 0) begin : g_nodly
            assign ref_d = b.ref_bus;
        end else begin : g_dly
            logic [W-1:0] dl [SKEW];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < SKEW; i++) dl[i] <= '0;
                end else if (b.en) begin
                    dl[0] <= b.ref_bus;
                    for (int i = 1; i < SKEW; i++) dl[i] <= dl[i-1];
                end
            end
            assign ref_d = dl[SKEW-1];
        end
    endgenerate

    // Warm-up: stale zeros in the delay line must not be compared.
    always_ff @(posedge clk) begin
        if (rst) begin
            st   <= (SKEW == 0) ? RUN : WARM;
            warm <= '0;
        end else begin
            st   <= st_n;
            warm <= (b.en && st == WARM) ? warm + 4'd1 : warm;
        end
    end

    always_comb begin
        st_n = (st == WARM && b.en && warm + 4'd1 == SK) ? RUN : st;
    end

    always_comb begin
        act   = b.en && st == RUN;
        diff  = (ref_d ^ b.dut_bus) & ~b.mask;
        hit   = act && |diff;
        first = hit && (!err_q || b.clr_err);
    end

`ifdef LOCKSTEP_HALT_EN
    always_ff @(posedge clk) begin
        if (rst) halt_q <= 1'b0;
        else     halt_q <= first ? 1'b1 : b.clr_err ? 1'b0 : halt_q;
    end
`else
    assign halt_q = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch_q    <= 1'b0;
            err_q         <= 1'b0;
            first_diff_q  <= '0;
            first_cycle_q <= '0;
            err_count_q   <= '0;
            cycle_q       <= '0;
        end else begin
            mismatch_q <= hit;
            if (first) begin
                err_q         <= 1'b1;
                first_diff_q  <= diff;
                first_cycle_q <= cycle_q;
            end else if (b.clr_err) begin
                err_q         <= 1'b0;
                first_diff_q  <= '0;
                first_cycle_q <= '0;
            end
            if (b.clr_err)
                err_count_q <= CNT_W'(hit);
            else if (hit && !halt_q && err_count_q != '1)
                err_count_q <= err_count_q + CNT_W'(1);
            if (b.en && !halt_q)
                cycle_q <= cycle_q + CNT_W'(1);
        end
    end

    assign b.out_bus     = b.dut_bus;
    assign b.mismatch    = mismatch_q;
    assign b.err         = err_q;
    assign b.halt        = halt_q;
    assign b.first_diff  = first_diff_q;
    assign b.first_cycle = first_cycle_q;
    assign b.err_count   = err_count_q;
    assign b.cycle       = cycle_q;
endmodule

// File: tb/tb_lockstep_compare.sv
// tb_lockstep_compare: directed scoreboard bench for three lockstep_compare configurations.
module tb_lockstep_compare;
`ifdef LOCKSTEP_HALT_EN
    localparam bit HALT = 1'b1;
`else
    localparam bit HALT = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   exp_q [$];
    logic [15:0] hist [$];

    always #5 clk = ~clk;

    lockstep_if #(.W(270), .CNT_W(32)) ia ();
    lockstep_if #(.W(16),  .CNT_W(32)) ib ();
    lockstep_if #(.W(8),   .CNT_W(4))  ic ();

    lockstep_compare #(.W(270), .SKEW(0), .CNT_W(32)) ua (.clk(clk), .rst(rst), .b(ia));
    lockstep_compare #(.W(16),  .SKEW(2), .CNT_W(32)) ub (.clk(clk), .rst(rst), .b(ib));
    lockstep_compare #(.W(8),   .SKEW(0), .CNT_W(4))  uc (.clk(clk), .rst(rst), .b(ic));

    task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_all();
        ia.en = 0; ia.clr_err = 0; ia.ref_bus = '0; ia.dut_bus = '0; ia.mask = '0;
        ib.en = 0; ib.clr_err = 0; ib.ref_bus = '0; ib.dut_bus = '0; ib.mask = '0;
        ic.en = 0; ic.clr_err = 0; ic.ref_bus = '0; ic.dut_bus = '0; ic.mask = '0;
    endtask

    task automatic do_rst();
        idle_all();
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic chk_a_zero(input string tag);
        chk({tag, "_mismatch"}, ia.mismatch, 0);
        chk({tag, "_err"}, ia.err, 0);
        chk({tag, "_halt"}, ia.halt, 0);
        chk({tag, "_first_diff"}, ia.first_diff, 0);
        chk({tag, "_first_cycle"}, ia.first_cycle, 0);
        chk({tag, "_err_count"}, ia.err_count, 0);
        chk({tag, "_cycle"}, ia.cycle, 0);
    endtask

    task automatic run_a(input int n, input int f0, input int f5, input logic m0);
        logic [287:0] r;
        logic [269:0] d;
        for (int t = 0; t < n; t++) begin
            for (int k = 0; k < 9; k++) r[k*32 +: 32] = $urandom;
            d = r[269:0];
            if (t == f0) d[0] = ~d[0];
            if (t == f5) d[5] = ~d[5];
            ia.en = 1; ia.ref_bus = r[269:0]; ia.dut_bus = d; ia.mask = {{269{1'b0}}, m0};
            exp_q.push_back((t == f0 && !m0) || t == f5);
            #1 chk("a_out_bus", ia.out_bus, d);
            @(posedge clk); #1;
            chk("a_mismatch", ia.mismatch, exp_q.pop_front());
        end
        ia.en = 0;
    endtask

    task automatic step_c(input logic e, input logic [7:0] d, input logic c, input logic x);
        ic.en = e; ic.ref_bus = 8'h00; ic.dut_bus = d; ic.clr_err = c;
        exp_q.push_back(x);
        @(posedge clk); #1;
        chk("c_mismatch", ic.mismatch, exp_q.pop_front());
        ic.clr_err = 0;
    endtask

    initial begin
        int k;
        logic [15:0] r, d;
        logic e, x;
        idle_all();
        do_rst();
        chk_a_zero("reset");
        chk("b_reset_cycle", ib.cycle, 0);
        chk("c_reset_err_count", ic.err_count, 0);

        run_a(100, -1, -1, 0);
        chk("clean_err", ia.err, 0);
        chk("clean_err_count", ia.err_count, 0);
        chk("clean_cycle", ia.cycle, 100);

        do_rst();
        run_a(45, 37, -1, 0);
        chk("flip_err", ia.err, 1);
        chk("flip_first_cycle", ia.first_cycle, 37);
        chk("flip_first_diff", ia.first_diff, 1);
        chk("flip_err_count", ia.err_count, 1);
        chk("flip_halt", ia.halt, HALT);
        chk("flip_cycle", ia.cycle, HALT ? 38 : 45);

        do_rst();
        run_a(45, 37, -1, 1);
        chk("masked_err", ia.err, 0);
        run_a(10, -1, 5, 1);
        chk("bit5_err", ia.err, 1);
        chk("bit5_first_diff", ia.first_diff, 288'h20);
        chk("bit5_first_cycle", ia.first_cycle, 50);
        chk("bit5_err_count", ia.err_count, 1);

        do_rst();
        run_a(15, 10, -1, 0);
        chk("halt_halt", ia.halt, HALT);
        chk("halt_cycle", ia.cycle, HALT ? 11 : 15);
        chk("halt_first_cycle", ia.first_cycle, 10);
        rst = 1; ia.en = 1; ia.clr_err = 1; ia.ref_bus = '0; ia.dut_bus = '1;
        @(posedge clk); #1;
        rst = 0; ia.en = 0; ia.clr_err = 0;
        chk_a_zero("midrst");

        // Skew 2 with a stall every fourth cycle; DUT trails the golden bus by two enabled cycles.
        do_rst();
        k = 0;
        hist.delete();
        for (int t = 0; t < 60; t++) begin
            e = (t % 4) != 3;
            r = 16'($urandom);
            d = 16'($urandom);
            x = 0;
            if (e) begin
                if (k >= 2) d = hist[k-2];
                if (k == 44) begin d ^= 16'h0100; x = 1; end
                hist.push_back(r);
                k++;
            end
            ib.en = e; ib.ref_bus = r; ib.dut_bus = d;
            exp_q.push_back(x);
            @(posedge clk); #1;
            chk("b_mismatch", ib.mismatch, exp_q.pop_front());
        end
        ib.en = 0;
        chk("b_cycle", ib.cycle, 45);
        chk("b_err", ib.err, 1);
        chk("b_first_cycle", ib.first_cycle, 44);
        chk("b_first_diff", ib.first_diff, 288'h0100);

        do_rst();
        for (int t = 0; t < 20; t++) step_c(1, 8'h01, 0, 1);
        chk("c_sat_err_count", ic.err_count, HALT ? 1 : 15);
        chk("c_wrap_cycle", ic.cycle, HALT ? 1 : 4);
        chk("c_sat_err", ic.err, 1);
        chk("c_sat_first_cycle", ic.first_cycle, 0);
        chk("c_sat_first_diff", ic.first_diff, 1);
        step_c(1, 8'h02, 1, 1);
        chk("c_clrhit_err", ic.err, 1);
        chk("c_clrhit_err_count", ic.err_count, 1);
        chk("c_clrhit_first_cycle", ic.first_cycle, HALT ? 1 : 4);
        chk("c_clrhit_first_diff", ic.first_diff, 2);
        chk("c_clrhit_halt", ic.halt, HALT);
        step_c(1, 8'h00, 1, 0);
        chk("c_clr_err", ic.err, 0);
        chk("c_clr_err_count", ic.err_count, 0);
        chk("c_clr_first_diff", ic.first_diff, 0);
        chk("c_clr_halt", ic.halt, 0);
        step_c(1, 8'h80, 0, 1);
        chk("c_rehit_err", ic.err, 1);
        step_c(0, 8'h80, 1, 0);
        chk("c_stallclr_err", ic.err, 0);
        chk("c_stallclr_err_count", ic.err_count, 0);
        chk("c_stallclr_cycle", ic.cycle, HALT ? 2 : 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lockstep_compare.md
Name: lockstep_compare

Overview:
- Parametrised lockstep checker between a golden core and a DUT core (e.g. picorv32 vs regenerated RTL), both driving the same packed output bus.
- Passes the DUT bus through unchanged, so it drops in as a core wrapper.
- Adds:
  - latency-skew alignment of the golden bus;
  - per-bit masking;
  - registered mismatch detection;
  - sticky error with first-failure capture;
  - a saturating error counter.

Parameters:
- W, 270, width of each packed output bus.
- SKEW, 0, cycles by which the DUT lags the golden core; the golden bus is delayed by SKEW enabled cycles. Legal range 0..15.
- CNT_W, 32, width of the cycle and error counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- en  in  1  compare/advance qualifier; low = stall (no compare, no delay-line shift, no counting).
- ref_bus  in  W  golden core outputs.
- dut_bus  in  W  DUT outputs.
- mask  in  W  1 = ignore this bit in comparison.
- clr_err  in  1  clears err, first_diff, first_cycle, err_count.
- out_bus  out  W  equals dut_bus, combinational, zero latency.
- mismatch  out  1  registered per-cycle mismatch flag.
- err  out  1  sticky error.
- first_diff  out  W  masked XOR vector of the first mismatch.
- first_cycle  out  CNT_W  cycle index of the first mismatch.
- err_count  out  CNT_W  number of mismatching cycles, saturating.
- cycle  out  CNT_W  count of enabled cycles since reset.
- halt  out  1  see Optional Feature.

Behaviour:
- Reset: one clock and one synchronous reset; rst is active-high and sampled on the rising edge of clk. While rst=1 at a clk edge:
  - mismatch, err, halt = 0;
  - first_diff, first_cycle, err_count, cycle = 0;
  - delay line = 0;
  - warm-up counter = 0.
  - rst overrides en and clr_err.
  - Reset mid-run discards all capture state; out_bus is unaffected.
- Skew alignment:
  - ref_d = ref_bus delayed by SKEW stages; each stage shifts only when en=1.
  - SKEW=0: ref_d = ref_bus combinationally.
- Warm-up:
  - A 4-bit counter counts enabled cycles up to SKEW, then holds.
  - Compares are suppressed until the counter equals SKEW, so stale zeros in the delay line are not flagged.
  - SKEW=0: no warm-up.
- Compare, on a cycle t with en=1 and warm-up complete:
  - diff = (ref_d ^ dut_bus) & ~mask;
  - hit = |diff.
- mismatch timing:
  - mismatch at t+1 = hit at t.
  - mismatch = 0 for cycles with en=0 or during warm-up.
- Capture, at the clock edge ending cycle t:
  - If hit and err=0: err<=1, first_diff<=diff, first_cycle<=cycle (pre-increment value).
  - Later hits update err_count only; first_* hold.
- err_count:
  - +1 per hit.
  - Saturates at 2^CNT_W-1 and never wraps.
- cycle:
  - +1 per en=1 cycle.
  - Wraps modulo 2^CNT_W; wrap does not affect err.
- clr_err:
  - Clears err, first_diff, first_cycle, err_count.
  - Does not clear cycle, the delay line or warm-up.
- clr_err with a hit in the same cycle: the hit wins. The result is err=1, err_count=1, and first_* are captured from this cycle.
- en=0 with clr_err=1: the clear still takes effect.
- No state machine beyond warm-up (WARM→RUN). RUN is left only on rst.

Optional Feature:
- Macro: LOCKSTEP_HALT_EN.
- Defined:
  - halt is registered and goes to 1 in the same edge that sets err.
  - While halt=1, cycle freezes and err_count freezes after its first increment, so the capture is preserved for debug.
  - halt clears only on rst or clr_err.
  - halt gates no other logic; the system uses it to stop both cores.
- Undefined:
  - halt tied to 0.
  - Counters behave as described in Behaviour.

Test Plan:
- Identical buses, SKEW=0, en=1 for 100 cycles → mismatch=0, err=0, err_count=0, cycle=100.
- Bit 0 (trap) of dut_bus flipped at cycle 37 only → mismatch=1 exactly at cycle 38, err=1, first_cycle=37, first_diff=1, err_count=1.
- Same flip with mask[0]=1 → no mismatch, err=0. Then a flip of bit 5 at cycle 50 → first_diff=0x20, first_cycle=50.
- SKEW=2, dut_bus = ref_bus delayed 2 cycles, random data, with en=0 stalls inserted → never a mismatch; warm-up suppresses the first 2 enabled cycles.
- Mismatch every cycle, CNT_W=4 → err_count saturates at 15. clr_err asserted together with a hit → err_count=1, err=1, first_cycle = that cycle.
- LOCKSTEP_HALT_EN defined, mismatch at cycle 10 → halt=1 at cycle 11, cycle frozen at 11. Then rst mid-run → all outputs 0 on the next edge.
